pwm_thres_buf: RTL and testbench

- Threshold store on the far side of the pwm block's `pwm_addr` / `pwm_data` / `latch_mem` interface. It answers the pwm's per-channel threshold reads.
- Double-buffered:
  - A host writes the shadow bank through a valid/ready port.
  - A committed shadow bank becomes active only on a `latch_mem` rising edge, so a PWM period never sees a torn update.
  - After each swap, the block copies the new active bank into the shadow bank, so partial host updates start from current values.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_thres_bank.sv | 36 +++
 rtl/pwm_thres_buf.sv | 124 ++++++++++++
 tb/tb_pwm_thres_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the pwm threshold store: buffer FSM states and threshold width helper.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } thres_buf_state_t;

  // A threshold needs one bit more than the counter so that full duty is representable.
  function automatic int thres_width(input int pwm_width);
    return pwm_width + 1;
  endfunction

endpackage

// File: rtl/pwm_thres_bank.sv
// One threshold bank: register array with a synchronous write port, a pwm-side read
// port and a copy-source read port (both combinational, zero for out-of-range addresses).
module pwm_thres_bank #(
  parameter int num_pwm    = 4,
  parameter int data_width = 4,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr_a,
  output logic [data_width-1:0] rdata_a,
  input  logic [addr_width-1:0] raddr_b,
  output logic [data_width-1:0] rdata_b
);

  logic [data_width-1:0] mem [num_pwm];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_pwm; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < num_pwm)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (32'(raddr_a) < num_pwm) rdata_a = mem[raddr_a];
    if (32'(raddr_b) < num_pwm) rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/pwm_thres_buf.sv
// Double-buffered pwm threshold store; the shadow bank swaps in on a latch_mem rising edge.
// Optional build macro PWM_THRES_CLAMP_EN clamps host-written thresholds to full duty.
module pwm_thres_buf
  import pwm_pkg::*;
#(
  parameter int pwm_width  = 3,
  parameter int num_pwm    = 4,
  parameter int addr_width = $clog2(num_pwm)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [pwm_width:0]    wr_data,
  input  logic                  commit,
  output logic                  commit_pending,
  input  logic [addr_width-1:0] pwm_addr,
  output logic [pwm_width:0]    pwm_data,
  input  logic                  latch_mem,
  output thres_buf_state_t      state_dbg
);

  localparam int tw = thres_width(pwm_width);
  localparam logic [addr_width-1:0] last_idx = addr_width'(num_pwm - 1);

  thres_buf_state_t      state_q, state_d;
  logic [addr_width-1:0] idx_q, idx_d;
  logic                  sel_q, sel_d;
  logic                  latch_q;
  logic                  latch_edge;
  logic                  host_we, copy_we;
  logic [tw-1:0]         host_data;
  logic [tw-1:0]         rd_pwm  [2];
  logic [tw-1:0]         rd_copy [2];
  logic [tw-1:0]         bank_wdata;
  logic [addr_width-1:0] bank_waddr;

  assign latch_edge = latch_mem & ~latch_q;
  assign state_dbg  = state_q;

`ifdef PWM_THRES_CLAMP_EN
  localparam logic [tw-1:0] full_duty = tw'(1) << pwm_width;
  assign host_data = (wr_data > full_duty) ? full_duty : wr_data;
`else
  assign host_data = wr_data;
`endif

  // Host port: a write transfers on a clock edge where wr_valid && wr_ready; while
  // wr_ready is low the host holds wr_valid/wr_addr/wr_data and nothing is written.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sel_d          = sel_q;
    wr_ready       = 1'b0;
    commit_pending = 1'b0;
    host_we        = 1'b0;
    copy_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        host_we  = wr_valid;
        if (commit) state_d = ARMED;
      end
      ARMED: begin
        commit_pending = 1'b1;
        if (latch_edge) begin
          sel_d   = ~sel_q;
          idx_d   = '0;
          state_d = COPY;
        end
      end
      COPY: begin
        commit_pending = 1'b1;
        copy_we        = 1'b1;
        idx_d          = idx_q + 1'b1;
        if (idx_q == last_idx) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= 1'b0;
      latch_q  <= 1'b0;
      pwm_data <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      latch_q  <= latch_mem;
      pwm_data <= rd_pwm[sel_q];
    end
  end

  // The shadow is whichever bank sel_q does not point at; COPY refills it from the active one.
  assign bank_waddr = copy_we ? idx_q : wr_addr;
  assign bank_wdata = copy_we ? rd_copy[sel_q] : host_data;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    pwm_thres_bank #(
      .num_pwm   (num_pwm),
      .data_width(tw),
      .addr_width(addr_width)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     ((sel_q != 1'(k)) && (host_we || copy_we)),
      .waddr  (bank_waddr),
      .wdata  (bank_wdata),
      .raddr_a(pwm_addr),
      .rdata_a(rd_pwm[k]),
      .raddr_b(idx_q),
      .rdata_b(rd_copy[k])
    );
  end

endmodule

// File: tb/tb_pwm_thres_buf.sv
// Randomized and directed bench for pwm_thres_buf against a bank-level reference model.
module tb_pwm_thres_buf;
  import pwm_pkg::*;

  localparam int pw = 3;
  localparam int np = 4;
  localparam int aw = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [aw-1:0] wr_addr = '0;
  logic [pw:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic          commit_pending;
  logic [aw-1:0] pwm_addr = '0;
  logic [pw:0]   pwm_data;
  logic          latch_mem = 1'b0;
  thres_buf_state_t state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the active table, the host-visible shadow table, and busy bookkeeping.
  logic [pw:0] m_act [np];
  logic [pw:0] m_shd [np];
  bit          m_armed;
  int          m_copy_left;
  bit          m_latch_prev;
  bit          m_ready;
  logic [pw:0] exp_q [$];

  pwm_thres_buf #(.pwm_width(pw), .num_pwm(np), .addr_width(aw)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending),
    .pwm_addr(pwm_addr), .pwm_data(pwm_data),
    .latch_mem(latch_mem), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [pw:0] stored_value(input logic [pw:0] v);
`ifdef PWM_THRES_CLAMP_EN
    return (v > (pw+1)'(1 << pw)) ? (pw+1)'(1 << pw) : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < np; i++) begin
      m_act[i] = '0;
      m_shd[i] = '0;
    end
    m_armed      = 0;
    m_copy_left  = 0;
    m_latch_prev = 0;
    m_ready      = 1;
    exp_q.delete();
  endtask

  // After a swap the copy-back makes the shadow equal the new active table, which is the
  // old shadow: so the shadow is unchanged and only the active table takes its contents.
  task automatic model_clock();
    bit rise;
    exp_q.push_back(m_act[pwm_addr]);
    rise = latch_mem && !m_latch_prev;
    m_latch_prev = latch_mem;
    if (m_copy_left > 0) begin
      m_copy_left--;
    end else if (m_armed) begin
      if (rise) begin
        for (int i = 0; i < np; i++) m_act[i] = m_shd[i];
        m_armed     = 0;
        m_copy_left = np;
      end
    end else begin
      if (wr_valid) m_shd[wr_addr] = stored_value(wr_data);
      if (commit) m_armed = 1;
    end
    m_ready = !m_armed && (m_copy_left == 0);
  endtask

  task automatic step();
    logic [pw:0] e;
    @(posedge clk);
    model_clock();
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("pwm_data", 32'(pwm_data), 32'(e));
    end
    check("wr_ready", 32'(wr_ready), 32'(m_ready));
    check("commit_pending", 32'(commit_pending), 32'(!m_ready));
    check("state_idle", 32'(state_dbg == IDLE), 32'(m_ready));
  endtask

  task automatic host_write(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = aw'(a);
    wr_data  = (pw+1)'(d);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic pulse_latch();
    latch_mem = 1'b1;
    step();
    latch_mem = 1'b0;
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(wr_ready), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pwm_data", 32'(pwm_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_pending", 32'(commit_pending), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_all_expect(input string tag, input logic [pw:0] v0, input logic [pw:0] v1,
                                 input logic [pw:0] v2, input logic [pw:0] v3);
    logic [pw:0] want [np];
    want = '{v0, v1, v2, v3};
    for (int i = 0; i < np; i++) begin
      pwm_addr = aw'(i);
      step();
      check(tag, 32'(pwm_data), 32'(want[i]));
    end
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Reset sweep, one-cycle read latency.
    for (int i = 0; i < np; i++) begin
      pwm_addr = aw'(i);
      step();
    end

    // Shadow writes are invisible without a commit, even across a latch edge.
    host_write(0, 4'b1001);
    host_write(1, 4'b1011);
    host_write(2, 4'b0101);
    pulse_latch();
    read_all_expect("no_commit", 0, 0, 0, 0);

    // Commit, then edge at E: read at E is old, at E+1 new; copy holds off writes 4 cycles.
    pulse_commit();
    step();
    check("armed_not_ready", 32'(wr_ready), 32'd0);
    pwm_addr  = 2'd1;
    latch_mem = 1'b1;
    step();
    latch_mem = 1'b0;
    check("swap_old", 32'(pwm_data), 32'd0);
    step();
    check("swap_new", 32'(pwm_data), 32'b1011);
    step();
    step();
    check("copy_busy", 32'(wr_ready), 32'd0);
    step();
    check("copy_done", 32'(wr_ready), 32'd1);

    // Partial update proves the copy-back.
    host_write(2, 4'b0011);
    pulse_commit();
    pulse_latch();
    wait_idle();
    read_all_expect("copy_back", 4'b1001, 4'b1011, 4'b0011, 4'b0000);

    // Write held through ARMED and COPY; commit during COPY causes no second swap.
    pulse_commit();
    wr_valid  = 1'b1;
    wr_addr   = 2'd3;
    wr_data   = 4'b0111;
    latch_mem = 1'b1;
    step();
    latch_mem = 1'b0;
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    while (!wr_ready) step();
    step();
    wr_valid = 1'b0;
    pulse_latch();
    read_all_expect("held_write_no_swap", 4'b1001, 4'b1011, 4'b0011, 4'b0000);
    pulse_commit();
    pulse_latch();
    wait_idle();
    read_all_expect("held_write", 4'b1001, 4'b1011, 4'b0011, 4'b0111);

    // Reset mid-COPY.
    pulse_commit();
    latch_mem = 1'b1;
    step();
    latch_mem = 1'b0;
    step();
    check("mid_copy", 32'(commit_pending), 32'd1);
    apply_reset();
    read_all_expect("post_reset", 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = aw'($urandom_range(0, np - 1));
      wr_data   = (pw+1)'($urandom_range(0, 15));
      commit    = ($urandom_range(0, 9) == 0);
      latch_mem = ($urandom_range(0, 4) == 0) ? ~latch_mem : latch_mem;
      pwm_addr  = aw'($urandom_range(0, np - 1));
      step();
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    latch_mem = 1'b0;
    step();
    wait_idle();

    // Over-range threshold on the host path.
    host_write(0, 4'b1111);
    pulse_commit();
    pulse_latch();
    wait_idle();
    pwm_addr = 2'd0;
    step();
`ifdef PWM_THRES_CLAMP_EN
    check("clamp", 32'(pwm_data), 32'b1000);
`else
    check("no_clamp", 32'(pwm_data), 32'b1111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
